// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: default datapath widths, the NOP opcode
// and the occupancy encoding used by the skid-buffered pipeline stages.
package cpu_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_OP_W       = 6;

  localparam logic [DEF_OP_W-1:0] DEF_NOP_OP = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_st_e;

endpackage

// File: rtl/stage_payload_reg.sv
// One packed payload register of a pipeline stage.
// Clear (or reset) wins over load and restores the idle pattern.
module stage_payload_reg #(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pay_q;
  logic [W-1:0] pay_d;

  always_comb begin
    pay_d = pay_q;
    if (clr_i)
      pay_d = CLR_VAL;
    else if (ld_i)
      pay_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pay_q <= CLR_VAL;
    else
      pay_q <= pay_d;
  end

  assign q_o = pay_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline stage: two-entry skid buffer with registered in_ready,
// flush and global rdy freeze. Main register is always the head entry.
module ex_mem_skid
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned OP_W       = DEF_OP_W,
  parameter logic [OP_W-1:0] NOP_OP = OP_W'(DEF_NOP_OP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_rd_data,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0]     in_mem_addr,
  input  logic [OP_W-1:0]       in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_rd_data,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [DATA_W-1:0]     out_mem_addr,
  output logic [OP_W-1:0]       out_op
);

  localparam int unsigned PW = 2*DATA_W + REG_ADDR_W + OP_W;
  localparam logic [PW-1:0] IDLE_PAY = {{(PW-OP_W){1'b0}}, NOP_OP};

  skid_st_e st_q, st_d;
  logic     in_rdy_q;

  logic          acc, cons;
  logic          main_ld, main_clr, main_from_skid;
  logic          skid_ld, skid_clr;
  logic [PW-1:0] in_pay, main_pay, skid_pay, main_din;

  assign in_pay = {in_rd_data, in_rd_addr, in_mem_addr, in_op};

  assign acc  = rdy && in_valid && in_rdy_q;
  assign cons = rdy && out_valid && out_ready;

  always_comb begin
    st_d           = st_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (!rdy) begin
      st_d = st_q;
    end else if (flush) begin
      st_d     = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (st_q)
        ST_EMPTY: begin
          if (acc) begin
            st_d    = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && cons) begin
            main_ld = 1'b1;
          end else if (acc) begin
            st_d    = ST_TWO;
            skid_ld = 1'b1;
          end else if (cons) begin
            st_d     = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_TWO: begin
          if (cons) begin
            st_d           = ST_ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: st_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready tracks the next state so it never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_EMPTY;
      in_rdy_q <= 1'b1;
    end else if (rdy) begin
      st_q     <= st_d;
      in_rdy_q <= (st_d != ST_TWO);
    end
  end

  assign main_din = main_from_skid ? skid_pay : in_pay;

  stage_payload_reg #(
    .W       (PW),
    .CLR_VAL (IDLE_PAY)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .ld_i  (main_ld),
    .clr_i (main_clr),
    .d_i   (main_din),
    .q_o   (main_pay)
  );

  stage_payload_reg #(
    .W       (PW),
    .CLR_VAL (IDLE_PAY)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .ld_i  (skid_ld),
    .clr_i (skid_clr),
    .d_i   (in_pay),
    .q_o   (skid_pay)
  );

  assign in_ready  = in_rdy_q;
  assign out_valid = (st_q != ST_EMPTY);
  assign {out_rd_data, out_rd_addr, out_mem_addr, out_op} = main_pay;

endmodule

// File: doc/ex_mem_skid.md
# ex_mem_skid

Parametrised EX→MEM pipeline stage with valid/ready handshake and a two-entry skid buffer. Successor to the fixed-width, stall-driven EX/MEM latch. It decouples the execute stage from memory-stage back-pressure without a combinational ready path, supports pipeline flush, and honours the global `rdy` freeze. It sits between the EX unit and the MEM unit in the CPU core.

## Interface
- `DATA_W`, 32: width of the rd result and of the memory address.
- `REG_ADDR_W`, 5: width of the destination register index.
- `OP_W`, 6: width of the opcode field.
- `NOP_OP`, all-zero: opcode value presented when no valid entry exists.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global enable; when 0, no state changes and no transfers.
- `flush`  in  1  discard all held entries; effective only when `rdy`=1.
- `in_valid`  in  1  EX presents an entry.
- `in_ready`  out  1  stage can accept; registered.
- `in_rd_data`  in  `DATA_W`  result to write back.
- `in_rd_addr`  in  `REG_ADDR_W`  destination register.
- `in_mem_addr`  in  `DATA_W`  effective memory address.
- `in_op`  in  `OP_W`  operation.
- `out_valid`  out  1  entry available to MEM.
- `out_ready`  in  1  MEM accepts the entry.
- `out_rd_data`, `out_rd_addr`, `out_mem_addr`, `out_op`  out  widths as inputs  head entry payload.

## Operation
- Accept when `rdy && in_valid && in_ready`. Consume when `rdy && out_valid && out_ready`.
- State is EMPTY, ONE or TWO. The main register is the output and is always the head. The skid register holds the second entry.
- EMPTY: accept → ONE, and main ← input.
- ONE:
  - accept and consume → ONE, main ← input.
  - accept only → TWO, skid ← input.
  - consume only → EMPTY.
  - otherwise hold.
- TWO: `in_ready`=0, so no accept. Consume → ONE, main ← skid. Otherwise hold.
- `in_ready` = (state ≠ TWO). It is a flop updated with the next state. It never depends combinationally on `out_ready`.
- `out_valid` = (state ≠ EMPTY).
- When `out_valid`=0, the payload outputs read as zero and `out_op`=`NOP_OP`. Empty registers are cleared on drain.
- Flush with `rdy`=1: next state is EMPTY and both registers clear to zero/`NOP_OP`. An input presented in the same cycle is dropped. A consume in that cycle still counts as having happened for MEM.
- `rdy`=0: all registers and state hold. `flush`, `in_valid` and `out_ready` are ignored.
- Priority, highest first: `rst`, then `rdy`=0 hold, then `flush`, then normal transitions.
- Ordering: entries exit in acceptance order, with no loss and no duplication.

## Timing
- Reset values, all applied on the first edge with `rst`=1, independent of `rdy`:
  - state EMPTY, `in_ready`=1, `out_valid`=0.
  - `out_rd_data`=0, `out_rd_addr`=0, `out_mem_addr`=0, `out_op`=`NOP_OP`.
- Latency: an entry accepted at edge N is visible on the outputs after edge N with `out_valid`=1, i.e. 1 cycle.
- Throughput: 1 entry/cycle sustained while `out_ready`=1.
- Back-pressure: after `out_ready` drops, at most one more entry is accepted (into skid), then `in_ready` falls on the following edge.
- After flush, `in_ready`=1 and `out_valid`=0 from the next cycle.
- Reset mid-operation discards both entries.

## Structure
- The shared package `cpu_pkg` holds `NOP_OP`, the default widths and the state enumeration (`ST_EMPTY`, `ST_ONE`, `ST_TWO`).
- Pack the payload internally as one vector of width `2*DATA_W+REG_ADDR_W+OP_W`.
- Sub-module `stage_payload_reg` is one payload register with load/clear controls. It is instantiated twice, as main and skid.
- The state machine and handshake logic stay in the top.

## Test plan
- Reset, then `rst`=0 idle → `in_ready`=1, `out_valid`=0, `out_op`=`NOP_OP`, all payload fields 0.
- Stream entries with `out_ready`=1 and `in_valid`=1, ops 1,2,3,4 in consecutive cycles → `out_op` shows 1,2,3,4 on consecutive cycles, one cycle behind input, with `in_ready` constantly 1.
- `out_ready`=0 and push ops 5,6,7 → 5 and 6 are accepted, `in_ready`=0 from the cycle after 6, and 7 is held by EX. Then `out_ready`=1 → outputs 5,6,7 in order with no duplicate.
- State TWO holding 8,9, assert `flush` with `in_valid`=1 and op 10 → next cycle `out_valid`=0, `in_ready`=1, and 8, 9 and 10 never appear.
- State ONE holding op 11 with `rdy`=0 for 3 cycles while `out_ready`=1 and `in_valid`=1 → no transfers and outputs unchanged. When `rdy` returns to 1, 11 is consumed exactly once.
- Assert `rst` while in state TWO with `rdy`=0 → next cycle is the full reset state.
